// File: rtl/tlc_pkg.sv
// Shared types and helpers for the N-way traffic light controller.
//   phase_t  : 2-bit phase encoding exposed on the phase output
//   width_of : clog2-based width with a floor of one bit
//   rr_next  : round-robin pick of the next sensed direction
package tlc_pkg;

  localparam int unsigned MAX_DIR = 8;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    EMERG   = 2'd3
  } phase_t;

  // Bits needed to index n values (never less than one).
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

  // First requesting direction after cur, wrapping, cur itself checked last.
  // With no request at all, cur is kept.
  function automatic logic [2:0] rr_next(input logic [MAX_DIR-1:0] req,
                                         input logic [2:0]         cur,
                                         input int unsigned        num);
    logic [2:0]  res;
    logic        found;
    logic [31:0] idx;
    res   = cur;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_DIR; k++) begin
      if (k <= num) begin
        idx = 32'(cur) + 32'(k);
        if (idx >= num) idx = idx - num;
        if (!found && req[idx[2:0]]) begin
          res   = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// Timing tick prescaler: counts 0..TICK_DIV-1 and pulses tick for one clk
// when the count wraps. Only rst clears the count.
//   clk, rst : clock, asynchronous active-high reset
//   tick     : one-clk pulse every TICK_DIV clks
module tlc_tick_gen
  import tlc_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW   = width_of(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Free-running prescaler with registered wrap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      if (cnt_q == LAST) cnt_q <= '0;
      else               cnt_q <= cnt_q + 1'b1;
      tick <= (cnt_q == LAST);
    end
  end

endmodule

// File: rtl/traffic_light_controller_nway.sv
// N-direction traffic light controller. One direction is green at a time,
// granted round-robin among sensed demand, with min/max green, yellow and
// all-red clearance timed in prescaled ticks, plus emergency override.
//   clk, rst          : clock, asynchronous active-high reset
//   sense             : per-direction vehicle sensors (level, asynchronous)
//   emerg_req         : emergency override request (level, asynchronous)
//   emerg_dir         : direction to force green (quasi-static)
//   red/yellow/green  : registered lamp drives, one lamp per direction
//   active_dir        : direction owning the current phase
//   phase             : 0=ALL_RED 1=GREEN 2=YELLOW 3=EMERG
module traffic_light_controller_nway
  import tlc_pkg::*;
#(
  parameter int unsigned NUM_DIR   = 4,
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned GREEN_MIN = 10,
  parameter int unsigned GREEN_MAX = 30,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_DIR-1:0]               sense,
  input  logic                             emerg_req,
  input  logic [width_of(NUM_DIR)-1:0]     emerg_dir,
  output logic [NUM_DIR-1:0]               red,
  output logic [NUM_DIR-1:0]               yellow,
  output logic [NUM_DIR-1:0]               green,
  output logic [width_of(NUM_DIR)-1:0]     active_dir,
  output logic [1:0]                       phase
);

  localparam int unsigned DIR_W = width_of(NUM_DIR);
  localparam int unsigned T_TOP =
    (GREEN_MAX >= YELLOW_T) ? ((GREEN_MAX >= ALLRED_T) ? GREEN_MAX : ALLRED_T)
                            : ((YELLOW_T  >= ALLRED_T) ? YELLOW_T  : ALLRED_T);
  localparam int unsigned CNT_W = width_of(T_TOP + 1);

  localparam logic [CNT_W-1:0] C_TOP = CNT_W'(T_TOP);
  localparam logic [CNT_W-1:0] G_MIN = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] G_MAX = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] Y_T   = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] A_T   = CNT_W'(ALLRED_T);

  logic [NUM_DIR-1:0] sense_meta, sense_s;
  logic               emerg_meta, emerg_s;
  logic               tick;

  phase_t             state_q, state_d;
  logic [DIR_W-1:0]   act_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_sat, sat_top;
  logic [NUM_DIR-1:0] red_d, yellow_d, green_d;
  logic [NUM_DIR-1:0] act_mask;
  logic               own, other, emerg_valid, emerg_act;

  tlc_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronisers for the asynchronous level inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sense_meta <= '0;
      sense_s    <= '0;
      emerg_meta <= 1'b0;
      emerg_s    <= 1'b0;
    end else begin
      sense_meta <= sense;
      sense_s    <= sense_meta;
      emerg_meta <= emerg_req;
      emerg_s    <= emerg_meta;
    end
  end

  // An emerg_dir outside 0..NUM_DIR-1 would light no lamp, so it is ignored.
  if ((1 << DIR_W) == NUM_DIR) begin : g_dir_full
    assign emerg_valid = 1'b1;
  end else begin : g_dir_part
    assign emerg_valid = (32'(emerg_dir) < NUM_DIR);
  end

  assign emerg_act = emerg_s & emerg_valid;
  assign act_mask  = NUM_DIR'(1) << active_dir;
  assign own       = |(sense_s & act_mask);
  assign other     = |(sense_s & ~act_mask);
  assign phase     = state_q;

  // Next phase, owner, phase counter and lamp decode.
  always_comb begin
    state_d  = state_q;
    act_d    = active_dir;
    cnt_d    = cnt_q;
    green_d  = '0;
    yellow_d = '0;
    red_d    = '1;

    sat_top = (state_q == GREEN) ? G_MAX : C_TOP;
    cnt_sat = (cnt_q >= sat_top) ? sat_top : cnt_q + 1'b1;
    if (tick) cnt_d = cnt_sat;

    case (state_q)
      ALL_RED: begin
        if (tick && (cnt_sat >= A_T)) begin
          if (emerg_act) begin
            state_d = EMERG;
            act_d   = emerg_dir;
          end else begin
            state_d = GREEN;
            act_d   = DIR_W'(rr_next(MAX_DIR'(sense_s), 3'(active_dir), NUM_DIR));
          end
        end
      end
      GREEN: begin
        // Emergency preempts green immediately, without waiting for a tick.
        if (emerg_act) begin
          state_d = (emerg_dir == active_dir) ? EMERG : YELLOW;
        end else if (tick && (cnt_sat >= G_MIN) && other &&
                     (!own || (cnt_sat == G_MAX))) begin
          state_d = YELLOW;
        end
      end
      YELLOW: begin
        if (tick && (cnt_sat >= Y_T)) state_d = ALL_RED;
      end
      EMERG: begin
        if (!emerg_s) state_d = GREEN;
      end
      default: state_d = ALL_RED;
    endcase

    if (state_d != state_q) cnt_d = '0;

    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      if (act_d == DIR_W'(i)) begin
        green_d[i]  = (state_d == GREEN) || (state_d == EMERG);
        yellow_d[i] = (state_d == YELLOW);
      end
    end
    red_d = ~(green_d | yellow_d);
  end

  // Phase state and registered lamp outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ALL_RED;
      active_dir <= '0;
      cnt_q      <= '0;
      red        <= '1;
      yellow     <= '0;
      green      <= '0;
    end else begin
      state_q    <= state_d;
      active_dir <= act_d;
      cnt_q      <= cnt_d;
      red        <= red_d;
      yellow     <= yellow_d;
      green      <= green_d;
    end
  end

endmodule

// File: tb/tb_traffic_light_controller_nway.sv
// Self-checking bench for traffic_light_controller_nway (4 directions,
// TICK_DIV=4, GREEN_MIN=3, GREEN_MAX=6, YELLOW_T=2, ALLRED_T=1).
// Directed scenarios measure phase lengths against fixed expectations;
// a background reference model is compared every cycle, including during
// a randomized sense/emergency run.
module tb_traffic_light_controller_nway;

  localparam int ND   = 4;
  localparam int TD   = 4;
  localparam int GMIN = 3;
  localparam int GMAX = 6;
  localparam int YT   = 2;
  localparam int AT   = 1;

  logic       clk;
  logic       rst;
  logic [3:0] sense;
  logic       emerg_req;
  logic [1:0] emerg_dir;
  logic [3:0] red, yellow, green;
  logic [1:0] active_dir;
  logic [1:0] phase;

  int n_cmp;
  int n_fail;
  bit mon_en;

  // Reference model state (phase as 0..3, owner, ticks in phase, edges since reset).
  int m_ph, m_dir, m_cnt, m_n;

  traffic_light_controller_nway #(
    .NUM_DIR   (ND),
    .TICK_DIV  (TD),
    .GREEN_MIN (GMIN),
    .GREEN_MAX (GMAX),
    .YELLOW_T  (YT),
    .ALLRED_T  (AT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sense      (sense),
    .emerg_req  (emerg_req),
    .emerg_dir  (emerg_dir),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .active_dir (active_dir),
    .phase      (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int rr_pick(input logic [3:0] req, input int cur);
    for (int k = 1; k <= ND; k++) begin
      if (req[(cur + k) % ND]) return (cur + k) % ND;
    end
    return cur;
  endfunction

  // Behavioural model: inputs reach the decision logic two edges late;
  // a tick is seen on edge n when n-1 is a positive multiple of TD.
  task automatic model_proc();
    logic [3:0] d1, d2, s;
    logic       e1, e2, e, t;
    int         c;
    d1 = '0; d2 = '0; e1 = 1'b0; e2 = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_ph = 0; m_dir = 0; m_cnt = 0; m_n = 0;
        d1 = '0; d2 = '0; e1 = 1'b0; e2 = 1'b0;
      end else begin
        m_n = m_n + 1;
        t = (m_n > 1) && (((m_n - 1) % TD) == 0);
        s = d2; e = e2;
        d2 = d1; d1 = sense;
        e2 = e1; e1 = emerg_req;
        case (m_ph)
          0: begin
            if (t && (m_cnt + 1 >= AT)) begin
              if (e) begin m_ph = 3; m_dir = int'(emerg_dir); end
              else   begin m_ph = 1; m_dir = rr_pick(s, m_dir); end
              m_cnt = 0;
            end else if (t) m_cnt = m_cnt + 1;
          end
          1: begin
            if (e) begin
              m_ph  = (int'(emerg_dir) != m_dir) ? 2 : 3;
              m_cnt = 0;
            end else if (t) begin
              c = (m_cnt + 1 > GMAX) ? GMAX : m_cnt + 1;
              if (c >= GMIN && ((s & ~(4'b0001 << m_dir)) != 4'b0) &&
                  (!s[m_dir] || c == GMAX)) begin
                m_ph = 2; m_cnt = 0;
              end else m_cnt = c;
            end
          end
          2: begin
            if (t && (m_cnt + 1 >= YT)) begin m_ph = 0; m_cnt = 0; end
            else if (t) m_cnt = m_cnt + 1;
          end
          default: begin
            if (!e) begin m_ph = 1; m_cnt = 0; end
          end
        endcase
      end
    end
  endtask

  // Every cycle: outputs against the model, plus lamp invariants.
  task automatic monitor();
    logic [3:0] eg, ey, er;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        eg = (m_ph == 1 || m_ph == 3) ? (4'b0001 << m_dir) : 4'b0000;
        ey = (m_ph == 2) ? (4'b0001 << m_dir) : 4'b0000;
        er = ~(eg | ey);
        n_cmp++;
        if ({phase, active_dir} !== {2'(m_ph), 2'(m_dir)}) begin
          n_fail++;
          $display("FAIL model_state t=%0t: phase/dir got %0d/%0d expected %0d/%0d",
                   $time, phase, active_dir, m_ph, m_dir);
        end
        n_cmp++;
        if ({red, yellow, green} !== {er, ey, eg}) begin
          n_fail++;
          $display("FAIL model_lamps t=%0t: r/y/g got %b/%b/%b expected %b/%b/%b",
                   $time, red, yellow, green, er, ey, eg);
        end
        n_cmp++;
        if ($countones(green) > 1 || $countones(yellow) > 1 ||
            (red | yellow | green) !== 4'hF ||
            (red & yellow) !== 4'h0 || (red & green) !== 4'h0 ||
            (yellow & green) !== 4'h0) begin
          n_fail++;
          $display("FAIL invariant t=%0t: r/y/g got %b/%b/%b expected one lamp per direction",
                   $time, red, yellow, green);
        end
      end
    end
  endtask

  task automatic do_reset(input logic [3:0] s);
    @(negedge clk);
    rst = 1'b1; sense = s; emerg_req = 1'b0; emerg_dir = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Count consecutive negedges (starting now) spent in phase ph.
  task automatic run_len(input logic [1:0] ph, output int len);
    len = 0;
    while (phase === ph && len < 1000) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; sense = 4'b0; emerg_req = 1'b0; emerg_dir = 2'd0;
    #1;
    mon_en = 1'b1;
    n_cmp++; if (red !== 4'hF)     begin n_fail++; $display("FAIL reset_red: got %b expected 1111", red); end
    n_cmp++; if (yellow !== 4'h0)  begin n_fail++; $display("FAIL reset_yellow: got %b expected 0000", yellow); end
    n_cmp++; if (green !== 4'h0)   begin n_fail++; $display("FAIL reset_green: got %b expected 0000", green); end
    n_cmp++; if (phase !== 2'd0)   begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    n_cmp++; if (active_dir !== 2'd0) begin n_fail++; $display("FAIL reset_dir: got %0d expected 0", active_dir); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rest_green();
    int r, ok;
    // First prescaler pulse is seen TD+1 edges after release.
    run_len(2'd0, r);
    n_cmp++; if (r !== TD + 1) begin n_fail++; $display("FAIL rest_allred_len: got %0d expected %0d", r, TD + 1); end
    n_cmp++;
    if (phase !== 2'd1 || green !== 4'b0001 || active_dir !== 2'd0) begin
      n_fail++;
      $display("FAIL rest_first_green: phase/green/dir got %0d/%b/%0d expected 1/0001/0", phase, green, active_dir);
    end
    ok = 0;
    repeat (200) begin
      @(negedge clk);
      if (green === 4'b0001 && phase === 2'd1 && red === 4'b1110) ok++;
    end
    n_cmp++; if (ok !== 200) begin n_fail++; $display("FAIL rest_hold: got %0d good cycles expected 200", ok); end
  endtask

  task automatic test_two_way();
    int r, g, y;
    do_reset(4'b0001);
    run_len(2'd0, r);
    n_cmp++; if (active_dir !== 2'd0 || green !== 4'b0001) begin n_fail++; $display("FAIL two_way_start: dir/green got %0d/%b expected 0/0001", active_dir, green); end
    sense = 4'b0100;
    run_len(2'd1, g);
    n_cmp++; if (g !== GMIN * TD) begin n_fail++; $display("FAIL two_way_green_len: got %0d expected %0d", g, GMIN * TD); end
    n_cmp++; if (yellow !== 4'b0001) begin n_fail++; $display("FAIL two_way_yellow: got %b expected 0001", yellow); end
    run_len(2'd2, y);
    n_cmp++; if (y !== YT * TD) begin n_fail++; $display("FAIL two_way_yellow_len: got %0d expected %0d", y, YT * TD); end
    run_len(2'd0, r);
    n_cmp++; if (r !== AT * TD) begin n_fail++; $display("FAIL two_way_allred_len: got %0d expected %0d", r, AT * TD); end
    n_cmp++;
    if (active_dir !== 2'd2 || green !== 4'b0100 || phase !== 2'd1) begin
      n_fail++;
      $display("FAIL two_way_grant: dir/green/phase got %0d/%b/%0d expected 2/0100/1", active_dir, green, phase);
    end
  endtask

  task automatic test_all_sense();
    int r, g, y, prev;
    do_reset(4'b0001);
    run_len(2'd0, r);
    sense = 4'b1111;
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (phase !== 2'd1 || int'(active_dir) != (k % ND) || int'(active_dir) == prev) begin
        n_fail++;
        $display("FAIL all_sense_order[%0d]: phase/dir got %0d/%0d expected 1/%0d", k, phase, active_dir, k % ND);
      end
      prev = int'(active_dir);
      if (k < 4) begin
        run_len(2'd1, g);
        n_cmp++; if (g !== GMAX * TD) begin n_fail++; $display("FAIL all_sense_green_len[%0d]: got %0d expected %0d", k, g, GMAX * TD); end
        run_len(2'd2, y);
        run_len(2'd0, r);
      end
    end
  endtask

  task automatic test_emerg_other();
    int r, k, y, ok, e, g;
    do_reset(4'b0010);
    run_len(2'd0, r);
    n_cmp++; if (active_dir !== 2'd1) begin n_fail++; $display("FAIL emerg_other_start: dir got %0d expected 1", active_dir); end
    repeat (5) @(negedge clk);
    emerg_dir = 2'd3;
    emerg_req = 1'b1;
    k = 0;
    while (phase !== 2'd2 && k < 20) begin @(negedge clk); k++; end
    n_cmp++; if (k !== 3 || yellow !== 4'b0010) begin n_fail++; $display("FAIL emerg_other_yellow: delay/yellow got %0d/%b expected 3/0010", k, yellow); end
    run_len(2'd2, y);
    n_cmp++; if (y !== YT * TD) begin n_fail++; $display("FAIL emerg_other_yellow_len: got %0d expected %0d", y, YT * TD); end
    run_len(2'd0, r);
    n_cmp++; if (r !== AT * TD) begin n_fail++; $display("FAIL emerg_other_allred_len: got %0d expected %0d", r, AT * TD); end
    n_cmp++;
    if (phase !== 2'd3 || green !== 4'b1000 || active_dir !== 2'd3) begin
      n_fail++;
      $display("FAIL emerg_other_grant: phase/green/dir got %0d/%b/%0d expected 3/1000/3", phase, green, active_dir);
    end
    ok = 0;
    repeat (50) begin
      @(negedge clk);
      if (phase === 2'd3 && green === 4'b1000) ok++;
    end
    n_cmp++; if (ok !== 50) begin n_fail++; $display("FAIL emerg_other_hold: got %0d good cycles expected 50", ok); end
    emerg_req = 1'b0;
    run_len(2'd3, e);
    n_cmp++; if (e !== 3 || active_dir !== 2'd3) begin n_fail++; $display("FAIL emerg_other_release: delay/dir got %0d/%0d expected 3/3", e, active_dir); end
    run_len(2'd1, g);
    n_cmp++;
    if (g < (GMIN - 1) * TD + 1 || g > GMIN * TD) begin
      n_fail++;
      $display("FAIL emerg_other_min_green: got %0d expected %0d..%0d", g, (GMIN - 1) * TD + 1, GMIN * TD);
    end
  endtask

  task automatic test_emerg_same();
    int r, k;
    do_reset(4'b0001);
    run_len(2'd0, r);
    emerg_dir = 2'd0;
    emerg_req = 1'b1;
    k = 0;
    while (phase !== 2'd3 && k < 20) begin @(negedge clk); k++; end
    n_cmp++; if (k !== 3) begin n_fail++; $display("FAIL emerg_same_delay: got %0d expected 3", k); end
    n_cmp++;
    if (green !== 4'b0001 || red !== 4'b1110 || yellow !== 4'b0000 || active_dir !== 2'd0) begin
      n_fail++;
      $display("FAIL emerg_same_lamps: r/y/g/dir got %b/%b/%b/%0d expected 1110/0000/0001/0", red, yellow, green, active_dir);
    end
    emerg_req = 1'b0;
    k = 0;
    while (phase !== 2'd1 && k < 20) begin @(negedge clk); k++; end
    n_cmp++; if (phase !== 2'd1 || green !== 4'b0001) begin n_fail++; $display("FAIL emerg_same_return: phase/green got %0d/%b expected 1/0001", phase, green); end
  endtask

  task automatic test_reset_mid_yellow();
    int r, g;
    do_reset(4'b0001);
    run_len(2'd0, r);
    sense = 4'b0100;
    run_len(2'd1, g);
    @(negedge clk);
    n_cmp++; if (phase !== 2'd2) begin n_fail++; $display("FAIL midrst_in_yellow: phase got %0d expected 2", phase); end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (red !== 4'hF || yellow !== 4'h0 || green !== 4'h0 || phase !== 2'd0 || active_dir !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_async: r/y/g/phase/dir got %b/%b/%b/%0d/%0d expected 1111/0000/0000/0/0",
               red, yellow, green, phase, active_dir);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_len(2'd0, r);
    n_cmp++; if (r !== TD + 1) begin n_fail++; $display("FAIL midrst_allred_len: got %0d expected %0d", r, TD + 1); end
    n_cmp++; if (active_dir !== 2'd2 || green !== 4'b0100) begin n_fail++; $display("FAIL midrst_grant: dir/green got %0d/%b expected 2/0100", active_dir, green); end
  endtask

  task automatic test_random();
    int hold;
    int start_cmp;
    do_reset(4'($urandom));
    hold = 0;
    start_cmp = n_cmp;
    repeat (4000) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) sense = 4'($urandom);
      if (emerg_req) begin
        if (hold == 0) emerg_req = 1'b0;
        else hold--;
      end else if ($urandom_range(0, 199) == 0) begin
        emerg_dir = 2'($urandom);
        emerg_req = 1'b1;
        hold = $urandom_range(0, 60);
      end
    end
    emerg_req = 1'b0;
    n_cmp++;
    if (n_cmp - 1 - start_cmp < 3 * 4000) begin
      n_fail++;
      $display("FAIL random_coverage: got %0d model comparisons expected %0d", n_cmp - 1 - start_cmp, 3 * 4000);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; mon_en = 1'b0;
    rst = 1'b0; sense = 4'b0; emerg_req = 1'b0; emerg_dir = 2'd0;
    fork
      model_proc();
      monitor();
    join_none
    test_reset();
    test_rest_green();
    test_two_way();
    test_all_sense();
    test_emerg_other();
    test_emerg_same();
    test_reset_mid_yellow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
